idu_rename_dispatch: RTL

Parametrised dual-issue dispatch unit with register renaming for the Tomasulo-style superscalar core. Accepts up to two in-order instructions per cycle from the fetch queue and allocates a free reservation station (RS) of the matching functional-unit type. It renames each source register to its producing RS tag, or to 0 when the value is already in the register file. Completion is tracked through a common data bus (CDB) that frees RS entries and clears register-status tags.

---
 rtl/idu_rename_dispatch.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/idu_rename_dispatch.sv
`default_nettype none
// ============================================================================
// Module  : idu_rename_dispatch
// Brief   : Dual-issue in-order dispatch with RS allocation, register renaming
//           and CDB-driven release of reservation stations / register tags.
// Revision: 1.0 - initial release
// ============================================================================
module idu_rename_dispatch #(
    parameter int NUM_FU_TYPES = 4,
    parameter int RS_PER_TYPE  = 2,
    parameter int NUM_REG      = 8,
    parameter int INS_PART_WID = 4,
    parameter int TAG_LEN      = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 inst_1_valid,
    input  logic [INS_PART_WID-1:0]              inst_1_type,
    input  logic [INS_PART_WID-1:0]              inst_1_dest,
    input  logic [INS_PART_WID-1:0]              inst_1_src0,
    input  logic [INS_PART_WID-1:0]              inst_1_src1,
    output logic                                 inst_1_fetch,
    input  logic                                 inst_2_valid,
    input  logic [INS_PART_WID-1:0]              inst_2_type,
    input  logic [INS_PART_WID-1:0]              inst_2_dest,
    input  logic [INS_PART_WID-1:0]              inst_2_src0,
    input  logic [INS_PART_WID-1:0]              inst_2_src1,
    output logic                                 inst_2_fetch,
    output logic                                 disp1_valid,
    output logic [TAG_LEN-1:0]                   disp1_rs_tag,
    output logic [TAG_LEN-1:0]                   disp1_src0_tag,
    output logic [TAG_LEN-1:0]                   disp1_src1_tag,
    output logic [INS_PART_WID-1:0]              disp1_src0_reg,
    output logic [INS_PART_WID-1:0]              disp1_src1_reg,
    output logic                                 disp2_valid,
    output logic [TAG_LEN-1:0]                   disp2_rs_tag,
    output logic [TAG_LEN-1:0]                   disp2_src0_tag,
    output logic [TAG_LEN-1:0]                   disp2_src1_tag,
    output logic [INS_PART_WID-1:0]              disp2_src0_reg,
    output logic [INS_PART_WID-1:0]              disp2_src1_reg,
    input  logic                                 cdb_valid,
    input  logic [TAG_LEN-1:0]                   cdb_tag,
    output logic [NUM_FU_TYPES*RS_PER_TYPE-1:0]  rs_busy,
    output logic [NUM_REG-1:0]                   reg_busy,
    output logic                                 illegal_err
);

    localparam int NUM_RS = NUM_FU_TYPES * RS_PER_TYPE;

    typedef logic [NUM_RS-1:0]                rs_vec_t;
    typedef logic [NUM_REG-1:0][TAG_LEN-1:0]  reg_tags_t;
    typedef struct packed {
        logic [TAG_LEN-1:0]      rs_tag;
        logic [TAG_LEN-1:0]      src0_tag;
        logic [TAG_LEN-1:0]      src1_tag;
        logic [INS_PART_WID-1:0] src0_reg;
        logic [INS_PART_WID-1:0] src1_reg;
    } disp_t;

    function automatic logic is_legal(input logic [INS_PART_WID-1:0] ty);
        return (int'(ty) >= 1) && (int'(ty) <= NUM_FU_TYPES);
    endfunction

    // Lowest-index free RS of functional-unit type ty, or -1 when none.
    function automatic int find_free(input rs_vec_t busy, input logic [INS_PART_WID-1:0] ty);
        int pick;
        pick = -1;
        for (int k = NUM_RS - 1; k >= 0; k--) begin
            if (((k / RS_PER_TYPE) == (int'(ty) - 1)) && !busy[k]) pick = k;
        end
        return pick;
    endfunction

    // Register-status lookup; out-of-range sources and tags completing now read as ready.
    function automatic logic [TAG_LEN-1:0] lookup(input reg_tags_t tags,
                                                  input logic [INS_PART_WID-1:0] src,
                                                  input logic hit,
                                                  input logic [TAG_LEN-1:0] htag);
        logic [TAG_LEN-1:0] t;
        t = '0;
        for (int r = 0; r < NUM_REG; r++) begin
            if (int'(src) == r) t = tags[r];
        end
        if (hit && (t == htag)) t = '0;
        return t;
    endfunction

    rs_vec_t   rs_busy_q, rs_busy_d;
    reg_tags_t reg_tag_q, reg_tag_d;
    logic      disp1_valid_q, disp1_valid_d;
    logic      disp2_valid_q, disp2_valid_d;
    disp_t     disp1_q, disp1_d;
    disp_t     disp2_q, disp2_d;
    logic      illegal_err_q, illegal_err_d;

    logic               legal_1, legal_2;
    logic               go_1, go_2;
    int                 pick_1, pick_2;
    rs_vec_t            alloc_1, alloc_2, cdb_free;
    logic               cdb_hit;
    logic [TAG_LEN-1:0] new_tag_1, new_tag_2;
    disp_t              ren_1, ren_2;

    always_comb begin
        legal_1  = is_legal(inst_1_type);
        legal_2  = is_legal(inst_2_type);

        // Only a broadcast naming a busy RS has any effect.
        cdb_hit  = 1'b0;
        cdb_free = '0;
        for (int k = 0; k < NUM_RS; k++) begin
            if (cdb_valid && (int'(cdb_tag) == k + 1) && rs_busy_q[k]) begin
                cdb_hit     = 1'b1;
                cdb_free[k] = 1'b1;
            end
        end

        pick_1       = find_free(rs_busy_q, inst_1_type);
        inst_1_fetch = rst_n && inst_1_valid && (!legal_1 || (pick_1 >= 0));
        go_1         = inst_1_fetch && legal_1;
        alloc_1      = '0;
        for (int k = 0; k < NUM_RS; k++) begin
            if (go_1 && (pick_1 == k)) alloc_1[k] = 1'b1;
        end
        new_tag_1    = TAG_LEN'(pick_1 + 1);

        pick_2       = find_free(rs_busy_q | alloc_1, inst_2_type);
        inst_2_fetch = rst_n && inst_2_valid && inst_1_fetch && (!legal_2 || (pick_2 >= 0));
        go_2         = inst_2_fetch && legal_2;
        alloc_2      = '0;
        for (int k = 0; k < NUM_RS; k++) begin
            if (go_2 && (pick_2 == k)) alloc_2[k] = 1'b1;
        end
        new_tag_2    = TAG_LEN'(pick_2 + 1);

        ren_1.rs_tag   = new_tag_1;
        ren_1.src0_tag = lookup(reg_tag_q, inst_1_src0, cdb_hit, cdb_tag);
        ren_1.src1_tag = lookup(reg_tag_q, inst_1_src1, cdb_hit, cdb_tag);
        ren_1.src0_reg = inst_1_src0;
        ren_1.src1_reg = inst_1_src1;

        // Slot 2 must see slot 1's destination as produced by slot 1's new RS.
        ren_2.rs_tag   = new_tag_2;
        ren_2.src0_tag = lookup(reg_tag_q, inst_2_src0, cdb_hit, cdb_tag);
        ren_2.src1_tag = lookup(reg_tag_q, inst_2_src1, cdb_hit, cdb_tag);
        if (go_1 && (inst_2_src0 == inst_1_dest) && (int'(inst_2_src0) < NUM_REG))
            ren_2.src0_tag = new_tag_1;
        if (go_1 && (inst_2_src1 == inst_1_dest) && (int'(inst_2_src1) < NUM_REG))
            ren_2.src1_tag = new_tag_1;
        ren_2.src0_reg = inst_2_src0;
        ren_2.src1_reg = inst_2_src1;
    end

    always_comb begin
        rs_busy_d = (rs_busy_q & ~cdb_free) | alloc_1 | alloc_2;

        // Later assignments take priority: CDB clear, then slot 1, then slot 2.
        for (int r = 0; r < NUM_REG; r++) begin
            reg_tag_d[r] = reg_tag_q[r];
            if (cdb_hit && (reg_tag_q[r] == cdb_tag)) reg_tag_d[r] = '0;
            if (go_1 && (int'(inst_1_dest) == r))    reg_tag_d[r] = new_tag_1;
            if (go_2 && (int'(inst_2_dest) == r))    reg_tag_d[r] = new_tag_2;
        end

        disp1_valid_d = go_1;
        disp2_valid_d = go_2;
        disp1_d       = go_1 ? ren_1 : disp1_q;
        disp2_d       = go_2 ? ren_2 : disp2_q;

        illegal_err_d = illegal_err_q
                      | (inst_1_fetch && !legal_1)
                      | (inst_2_fetch && !legal_2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs_busy_q     <= '0;
            reg_tag_q     <= '0;
            disp1_valid_q <= 1'b0;
            disp2_valid_q <= 1'b0;
            disp1_q       <= '0;
            disp2_q       <= '0;
            illegal_err_q <= 1'b0;
        end else begin
            rs_busy_q     <= rs_busy_d;
            reg_tag_q     <= reg_tag_d;
            disp1_valid_q <= disp1_valid_d;
            disp2_valid_q <= disp2_valid_d;
            disp1_q       <= disp1_d;
            disp2_q       <= disp2_d;
            illegal_err_q <= illegal_err_d;
        end
    end

    for (genvar r = 0; r < NUM_REG; r++) begin : g_reg_busy
        assign reg_busy[r] = |reg_tag_q[r];
    end

    assign rs_busy        = rs_busy_q;
    assign illegal_err    = illegal_err_q;
    assign disp1_valid    = disp1_valid_q;
    assign disp1_rs_tag   = disp1_q.rs_tag;
    assign disp1_src0_tag = disp1_q.src0_tag;
    assign disp1_src1_tag = disp1_q.src1_tag;
    assign disp1_src0_reg = disp1_q.src0_reg;
    assign disp1_src1_reg = disp1_q.src1_reg;
    assign disp2_valid    = disp2_valid_q;
    assign disp2_rs_tag   = disp2_q.rs_tag;
    assign disp2_src0_tag = disp2_q.src0_tag;
    assign disp2_src1_tag = disp2_q.src1_tag;
    assign disp2_src0_reg = disp2_q.src0_reg;
    assign disp2_src1_reg = disp2_q.src1_reg;

endmodule
`default_nettype wire
